// File: rtl/seven_segment_reader.sv
// Recovers hex digits from an external multiplexed seven-segment bus and
// emits a complete DIGITS-wide word once every digit has been captured.
module seven_segment_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 65536,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     digit_sel_in,
    output logic [4*DIGITS-1:0]   data,
    output logic                  frame_valid,
    output logic [DIGITS-1:0]     err_digits,
    output logic                  frame_err,
    output logic                  stale
);

    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] INV = (ACTIVE_LOW != 0) ? {SW{1'b1}} : {SW{1'b0}};

    typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;

    logic [SW-1:0]       sync1_reg, sync2_reg, prev_reg;
    logic [SW-1:0]       sample;
    logic [DIGITS-1:0]   sel;
    logic [6:0]          seg;
    logic                sel_onehot;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic                capture;

    logic [3:0]          dec_nib;
    logic                dec_err;

    logic [3:0]          nib_reg [DIGITS];
    logic [DIGITS-1:0]   err_hold_reg;
    logic [4*DIGITS-1:0] hold_nibs;
    logic [DIGITS-1:0]   seen_reg, seen_next, cap_bits;
    logic                emit;

    logic [TW-1:0]       to_cnt_reg;
    logic                to_hit;

    logic [4*DIGITS-1:0] data_reg;
    logic [DIGITS-1:0]   err_digits_reg;
    logic                frame_err_reg, frame_valid_reg, stale_reg;

    // The sample is the whole bus, so a select change counts as a change even
    // when two adjacent digits show the same glyph.
    assign sample     = sync2_reg ^ INV;
    assign sel        = sample[SW-1:7];
    assign seg        = sample[6:0];
    assign sel_onehot = $onehot(sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
            state_reg <= WAIT;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= {digit_sel_in, seg_in};
            sync2_reg <= sync1_reg;
            prev_reg  <= sample;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        if (sample != prev_reg) begin
            cnt_next   = '0;
            state_next = sel_onehot ? COUNT : WAIT;
        end else begin
            case (state_reg)
                WAIT: begin
                    cnt_next = '0;
                    if (sel_onehot) state_next = COUNT;
                end
                COUNT: begin
                    // cnt counts repeats; capture on the STABLE_CYCLES-th identical sample
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(STABLE_CYCLES - 2)) begin
                        capture    = 1'b1;
                        state_next = HELD;
                    end
                end
                HELD: ;
                default: state_next = WAIT;
            endcase
        end
    end

    always_comb begin
        dec_nib = 4'h0;
        dec_err = 1'b0;
        case (seg)
            7'h7E: dec_nib = 4'h0;
            7'h30: dec_nib = 4'h1;
            7'h6D: dec_nib = 4'h2;
            7'h79: dec_nib = 4'h3;
            7'h33: dec_nib = 4'h4;
            7'h5B: dec_nib = 4'h5;
            7'h5F: dec_nib = 4'h6;
            7'h70: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h7B: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h1F: dec_nib = 4'hB;
            7'h4E: dec_nib = 4'hC;
            7'h3D: dec_nib = 4'hD;
            7'h4F: dec_nib = 4'hE;
            7'h47: dec_nib = 4'hF;
            default: dec_err = 1'b1;
        endcase
    end

    assign cap_bits = capture ? sel : '0;
    assign emit     = &seen_reg;
    assign to_hit   = !capture && (to_cnt_reg == TW'(TIMEOUT - 1));

    // A capture in the emission cycle seeds the next frame.
    assign seen_next = (emit || to_hit) ? cap_bits : (seen_reg | cap_bits);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_pack
            assign hold_nibs[4*gi +: 4] = nib_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) nib_reg[i] <= '0;
            err_hold_reg <= '0;
            seen_reg     <= '0;
            to_cnt_reg   <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (cap_bits[i]) begin
                    nib_reg[i]      <= dec_nib;
                    err_hold_reg[i] <= dec_err;
                end
            end
            seen_reg   <= seen_next;
            to_cnt_reg <= (capture || to_hit) ? '0 : to_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg        <= '0;
            err_digits_reg  <= '0;
            frame_err_reg   <= 1'b0;
            frame_valid_reg <= 1'b0;
            stale_reg       <= 1'b0;
        end else begin
            frame_valid_reg <= emit;
            if (emit) begin
                data_reg       <= hold_nibs;
                err_digits_reg <= err_hold_reg;
                frame_err_reg  <= |err_hold_reg;
                stale_reg      <= 1'b0;
            end else if (to_hit) begin
                stale_reg      <= 1'b1;
            end
        end
    end

    assign data        = data_reg;
    assign err_digits  = err_digits_reg;
    assign frame_err   = frame_err_reg;
    assign frame_valid = frame_valid_reg;
    assign stale       = stale_reg;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader: one active-high and one
// active-low instance, expected frames queued as each scan is driven.
module tb_seven_segment_reader;

    localparam int TOUT = 300;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [6:0]  seg0, seg1;
    logic [3:0]  sel0, sel1;
    logic [15:0] data0, data1;
    logic        fv0, fv1, ferr0, ferr1, stale0, stale1;
    logic [3:0]  err0, err1;

    int tests = 0;
    int fails = 0;
    int frames0 = 0;
    int frames1 = 0;
    int n;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  err;
        logic        ferr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    seven_segment_reader #(.DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT(TOUT), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst(rst0), .seg_in(seg0), .digit_sel_in(sel0),
        .data(data0), .frame_valid(fv0), .err_digits(err0), .frame_err(ferr0), .stale(stale0)
    );

    seven_segment_reader #(.DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT(TOUT), .ACTIVE_LOW(1)) u_dut_al (
        .clk(clk), .rst(rst1), .seg_in(seg1), .digit_sel_in(sel1),
        .data(data1), .frame_valid(fv1), .err_digits(err1), .frame_err(ferr1), .stale(stale1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fv0) begin
            frames0++;
            $display("[TB] dut0 frame data=%h err=%b ferr=%b", data0, err0, ferr0);
            if (q0.size() == 0) begin
                check("dut0 unexpected frame", q0.size(), 1);
            end else begin
                e0 = q0.pop_front();
                check("dut0 data", data0, e0.data);
                check("dut0 err_digits", err0, e0.err);
                check("dut0 frame_err", ferr0, e0.ferr);
                check("dut0 stale at frame", stale0, 0);
            end
        end
        if (fv1) begin
            frames1++;
            $display("[TB] dut_al frame data=%h err=%b ferr=%b", data1, err1, ferr1);
            if (q1.size() == 0) begin
                check("dut_al unexpected frame", q1.size(), 1);
            end else begin
                e1 = q1.pop_front();
                check("dut_al data", data1, e1.data);
                check("dut_al err_digits", err1, e1.err);
                check("dut_al frame_err", ferr1, e1.ferr);
                check("dut_al stale at frame", stale1, 0);
            end
        end
    end

    task automatic show0(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
        sel0 = sel;
        seg0 = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Takes logical values and drives the inverted pins.
    task automatic show1(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
        sel1 = ~sel;
        seg1 = ~seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic scan0(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2, input logic [6:0] g3);
        show0(4'b0001, g0, 10);
        show0(4'b0010, g1, 10);
        show0(4'b0100, g2, 10);
        show0(4'b1000, g3, 10);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        sel0 = 4'h0; seg0 = 7'h00;
        sel1 = 4'hF; seg1 = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check("reset data", data0, 0);
        check("reset err_digits", err0, 0);
        check("reset frame_err", ferr0, 0);
        check("reset frame_valid", fv0, 0);
        check("reset stale", stale0, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        show0(4'b0000, 7'h00, 5);

        // Basic scan
        q0.push_back('{data: 16'h0543, err: 4'b0000, ferr: 1'b0});
        scan0(7'h79, 7'h33, 7'h5B, 7'h7E);

        // Glitch: 0x30 for only three samples must not be captured
        q0.push_back('{data: 16'h0523, err: 4'b0000, ferr: 1'b0});
        show0(4'b0001, 7'h79, 10);
        show0(4'b0010, 7'h30, 3);
        show0(4'b0010, 7'h6D, 10);
        show0(4'b0100, 7'h5B, 10);
        show0(4'b1000, 7'h7E, 10);

        // Illegal blank glyph on digit 2
        q0.push_back('{data: 16'h8088, err: 4'b0100, ferr: 1'b1});
        scan0(7'h7F, 7'h7F, 7'h00, 7'h7F);
        show0(4'b0000, 7'h00, 5);
        check("frames after three scans", frames0, 3);

        // Non-one-hot select never captures
        n = frames0;
        show0(4'b0011, 7'h7F, 50);
        show0(4'b0000, 7'h7F, 50);
        check("non-one-hot no frame", frames0, n);

        // Timeout discards the partial frame and raises stale
        show0(4'b0001, 7'h79, 10);
        show0(4'b0010, 7'h33, 10);
        show0(4'b0000, 7'h00, TOUT + 20);
        check("timeout stale", stale0, 1);
        check("timeout data kept", data0, 16'h8088);
        show0(4'b0100, 7'h6D, 10);
        show0(4'b1000, 7'h79, 10);
        show0(4'b0000, 7'h00, 20);
        check("partial after timeout no frame", frames0, n);
        q0.push_back('{data: 16'h3210, err: 4'b0000, ferr: 1'b0});
        show0(4'b0001, 7'h7E, 10);
        show0(4'b0010, 7'h30, 10);
        show0(4'b0000, 7'h00, 10);
        check("rescan frame count", frames0, n + 1);
        check("stale cleared", stale0, 0);

        // Active-low instance: "A" on every digit
        q1.push_back('{data: 16'hAAAA, err: 4'b0000, ferr: 1'b0});
        show1(4'b0001, 7'h77, 10);
        show1(4'b0010, 7'h77, 10);
        show1(4'b0100, 7'h77, 10);
        show1(4'b1000, 7'h77, 10);
        show1(4'b0000, 7'h00, 5);
        check("al first frame", frames1, 1);
        show1(4'b0001, 7'h77, 10);
        show1(4'b0010, 7'h77, 10);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        check("al reset data", data1, 0);
        check("al reset err_digits", err1, 0);
        check("al reset frame_err", ferr1, 0);
        check("al reset frame_valid", fv1, 0);
        check("al reset stale", stale1, 0);
        rst1 = 1'b0;
        show1(4'b0100, 7'h77, 10);
        show1(4'b1000, 7'h77, 10);
        show1(4'b0000, 7'h00, 10);
        check("al partial after reset no frame", frames1, 1);
        q1.push_back('{data: 16'hAA55, err: 4'b0000, ferr: 1'b0});
        show1(4'b0001, 7'h5B, 10);
        show1(4'b0010, 7'h5B, 10);
        show1(4'b0000, 7'h00, 10);
        check("al post-reset frame", frames1, 2);

        check("dut0 queue drained", q0.size(), 0);
        check("dut_al queue drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Receive-side counterpart of the hex-to-segment display decoder.
- Samples an external multiplexed seven-segment bus (segment lines plus one-hot digit select) and recovers the hex nibble shown on each digit.
- Emits a complete multi-digit word once every digit has been captured in a scan frame.
- Used to read back instrument or legacy-board displays into the fabric.

Parameters:
- DIGITS, 4, number of multiplexed digits (1-8).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (≥2).
- TIMEOUT, 65536, clk cycles with no capture before the partial frame is discarded.
- ACTIVE_LOW, 0, 1 = seg_in and digit_sel_in are active-low; both are inverted after synchronization.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  7  segment lines: bit6 top, 5 upper-right, 4 lower-right, 3 bottom, 2 lower-left, 1 upper-left, 0 middle.
- digit_sel_in  input  DIGITS  one-hot digit enable; bit i selects digit i.
- data  output  4*DIGITS  last complete word; digit i in data[4i+3:4i].
- frame_valid  output  1  one-cycle pulse when data/err_digits/frame_err update.
- err_digits  output  DIGITS  per-digit flag: captured pattern was not a legal hex glyph.
- frame_err  output  1  OR of err_digits for the emitted frame.
- stale  output  1  high after a timeout; low again on the next frame_valid.

Behaviour:
- seg_in and digit_sel_in each pass through a two-flop synchronizer, then the ACTIVE_LOW inversion. "Sample" below means the synchronized, inverted value {sel, seg}.
- Legal glyph table, pattern -> nibble:
  - 0x7E->0, 0x30->1, 0x6D->2, 0x79->3, 0x33->4, 0x5B->5, 0x5F->6, 0x70->7
  - 0x7F->8, 0x7B->9, 0x77->A, 0x1F->B, 0x4E->C, 0x3D->D, 0x4F->E, 0x47->F
  - Any other pattern, including blank 0x00, is illegal: nibble 0, error flag set.
- Stability FSM, states WAIT, COUNT, HELD; match counter cnt:
  - WAIT: sel not one-hot. Stays in WAIT while sel is not one-hot; cnt=0; moves to COUNT when sel becomes one-hot.
  - COUNT: sample equal to previous sample -> cnt+1. When cnt reaches STABLE_CYCLES-1 (pattern held for STABLE_CYCLES samples), capture this cycle and go to HELD.
  - Any sample change in COUNT or HELD -> cnt=0; go to COUNT if the new sel is one-hot, else WAIT.
  - HELD: no further captures until the sample changes. One capture per stable period.
- Capture of digit i:
  - Stores nibble and error flag into per-digit holding registers.
  - Sets seen[i].
  - Clears the timeout counter.
  - Recapturing an already-seen digit overwrites its holding value; seen is unaffected.
- Frame emission:
  - Cycle after seen becomes all-ones: data <= holding nibbles, err_digits <= holding flags, frame_err <= |flags, frame_valid=1, stale=0, seen cleared.
  - A capture landing in the emission cycle counts toward the next frame.
  - Outputs hold between frames.
- Timeout:
  - Counter increments each cycle with no capture.
  - On reaching TIMEOUT: seen cleared, stale=1, counter restarts.
  - data is not altered.
- Reset (synchronous, active-high), all to 0:
  - Outputs data, err_digits, frame_err, frame_valid, stale.
  - Internal: synchronizers, holding registers, seen, cnt, timeout counter; FSM to WAIT.
  - Reset mid-frame discards the partial frame; the first post-reset frame requires fresh captures of all digits.
- Latency: input change -> capture = 2 (sync) + STABLE_CYCLES cycles; last capture -> frame_valid = 1 cycle.

Test Plan:
- DIGITS=4, ACTIVE_LOW=0: scan digits 0..3 showing 0x79, 0x33, 0x5B, 0x7E, each held 10 cycles -> one frame_valid, data=16'h0543, err_digits=0, frame_err=0.
- Glitch rejection: digit 1 bus shows 0x30 for STABLE_CYCLES-1 samples, then 0x6D held 10 cycles -> digit 1 captured as 2, never 1.
- Illegal glyph: digit 2 shows 0x00, others legal (digits 0,1,3 = 0x7F) -> data=16'h8088, err_digits=4'b0100, frame_err=1.
- Non-one-hot select: digit_sel_in=4'b0011 or 4'b0000 held 50 cycles -> no capture, no frame_valid.
- Timeout: capture digits 0,1 then idle TIMEOUT cycles -> stale=1, data unchanged. Full rescan -> frame_valid, stale=0.
- ACTIVE_LOW=1 plus reset: inverted bus showing "A" (0x08 on the pins) on all digits -> data=16'hAAAA. Assert rst mid-second-frame -> all outputs 0 next cycle; the next frame needs all 4 digits recaptured.
